contador_descendente: RTL and testbench

//  Programmable N-bit down-counter/timer; the count-down counterpart of the up-counter contadorN.

---
 rtl/contador_descendente_pkg.sv | 12 +
 rtl/contador_descendente.sv | 83 ++++++++
 tb/tb_contador_descendente.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/contador_descendente_pkg.sv
// Shared definitions for contador_descendente.
// Holds the controller state type and the default counter width.
package contador_descendente_pkg;

  localparam int unsigned BITS_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/contador_descendente.sv
// contador_descendente: programmable down-counter / timer.
// Loads a start value, decrements once per enabled clock and pulses Tc for
// one clock at terminal count. One-shot (stop at 0) or periodic (auto-reload).
// All registers update on the falling edge of NEclk.
// Ports:
//   NEclk      in   clock, falling-edge active
//   Nreset     in   asynchronous active-low reset
//   Enable     in   count enable, low holds the count
//   Load       in   load LoadValue and start
//   LoadValue  in   start/reload value (unsigned, BITS wide)
//   Periodic   in   1 = auto-reload at terminal count, 0 = one-shot
//   Stop       in   synchronous abort to IDLE (beats Load)
//   count      out  current count
//   Busy       out  high while running
//   Tc         out  one-clock terminal-count pulse
module contador_descendente
  import contador_descendente_pkg::*;
#(
  parameter int unsigned BITS = BITS_DEFAULT
) (
  input  logic            NEclk,
  input  logic            Nreset,
  input  logic            Enable,
  input  logic            Load,
  input  logic [BITS-1:0] LoadValue,
  input  logic            Periodic,
  input  logic            Stop,
  output logic [BITS-1:0] count,
  output logic            Busy,
  output logic            Tc
);

  state_t          state, state_n;
  logic [BITS-1:0] reload, reload_n;
  logic [BITS-1:0] count_n;
  logic            tc_n;

  // Next-state and datapath; priority Stop > Load > counting.
  always_comb begin
    state_n  = state;
    reload_n = reload;
    count_n  = count;
    tc_n     = 1'b0;
    if (Stop) begin
      state_n = IDLE;
    end else if (Load) begin
      reload_n = LoadValue;
      count_n  = LoadValue;
      state_n  = (LoadValue != '0) ? RUN : IDLE;
    end else if (state == RUN && Enable) begin
      if (count > BITS'(1)) begin
        count_n = count - BITS'(1);
      end else begin
        // RUN is only entered with a non-zero value, so this is count==1.
        tc_n = 1'b1;
        if (Periodic) begin
          count_n = reload;
        end else begin
          count_n = '0;
          state_n = IDLE;
        end
      end
    end
  end

  // Busy is decoded from the next state so it changes on the same edge as state.
  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      state  <= IDLE;
      reload <= '0;
      count  <= '0;
      Tc     <= 1'b0;
      Busy   <= 1'b0;
    end else begin
      state  <= state_n;
      reload <= reload_n;
      count  <= count_n;
      Tc     <= tc_n;
      Busy   <= (state_n == RUN);
    end
  end

endmodule

// File: tb/tb_contador_descendente.sv
// Directed self-checking bench for contador_descendente (BITS=8).
module tb_contador_descendente;

  logic       NEclk = 1'b0;
  logic       Nreset;
  logic       Enable;
  logic       Load;
  logic [7:0] LoadValue;
  logic       Periodic;
  logic       Stop;
  logic [7:0] count;
  logic       Busy;
  logic       Tc;

  int total = 0;
  int bad   = 0;

  contador_descendente #(.BITS(8)) dut (
    .NEclk     (NEclk),
    .Nreset    (Nreset),
    .Enable    (Enable),
    .Load      (Load),
    .LoadValue (LoadValue),
    .Periodic  (Periodic),
    .Stop      (Stop),
    .count     (count),
    .Busy      (Busy),
    .Tc        (Tc)
  );

  always #5 NEclk = ~NEclk;

  task automatic tick;
    @(negedge NEclk);
    #1;
  endtask

  task automatic test_reset;
    Nreset = 1'b0; Enable = 1'b0; Load = 1'b0; LoadValue = '0;
    Periodic = 1'b0; Stop = 1'b0;
    #3;
    total++;
    if ({count, Busy, Tc} !== {8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_initial: got count=%0d busy=%b tc=%b want 0/0/0", count, Busy, Tc);
    end
    tick;
    Nreset = 1'b1;
    tick;
    total++;
    if ({count, Busy, Tc} !== {8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_release: got count=%0d busy=%b tc=%b want 0/0/0", count, Busy, Tc);
    end
    // run from 9 down to 7, then reset between edges
    LoadValue = 8'd9; Load = 1'b1; Enable = 1'b1;
    tick;
    Load = 1'b0;
    tick;
    tick;
    total++;
    if ({count, Busy, Tc} !== {8'd7, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_prerun: got count=%0d busy=%b tc=%b want 7/1/0", count, Busy, Tc);
    end
    #2;
    Nreset = 1'b0;
    #1;
    total++;
    if ({count, Busy, Tc} !== {8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_async: got count=%0d busy=%b tc=%b want 0/0/0", count, Busy, Tc);
    end
    #1;
    Nreset = 1'b1;
    tick;
    total++;
    if ({count, Busy, Tc} !== {8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_after: got count=%0d busy=%b tc=%b want 0/0/0", count, Busy, Tc);
    end
  endtask

  task automatic test_oneshot;
    int ec[7] = '{4, 3, 2, 1, 0, 0, 0};
    bit eb[7] = '{1, 1, 1, 1, 0, 0, 0};
    bit et[7] = '{0, 0, 0, 0, 1, 0, 0};
    Periodic = 1'b0; Enable = 1'b1; LoadValue = 8'd5; Load = 1'b1;
    tick;
    Load = 1'b0;
    total++;
    if ({count, Busy, Tc} !== {8'd5, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL oneshot_load: got count=%0d busy=%b tc=%b want 5/1/0", count, Busy, Tc);
    end
    for (int i = 0; i < 7; i++) begin
      tick;
      total++;
      if ({count, Busy, Tc} !== {8'(ec[i]), eb[i], et[i]}) begin
        bad++;
        $display("FAIL oneshot_step%0d: got count=%0d busy=%b tc=%b want %0d/%b/%b",
                 i, count, Busy, Tc, ec[i], eb[i], et[i]);
      end
    end
  endtask

  task automatic test_periodic;
    int ec[7] = '{2, 1, 3, 2, 1, 3, 2};
    bit et[7] = '{0, 0, 1, 0, 0, 1, 0};
    Periodic = 1'b1; Enable = 1'b1; LoadValue = 8'd3; Load = 1'b1;
    tick;
    Load = 1'b0;
    total++;
    if ({count, Busy, Tc} !== {8'd3, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL periodic_load: got count=%0d busy=%b tc=%b want 3/1/0", count, Busy, Tc);
    end
    for (int i = 0; i < 7; i++) begin
      tick;
      total++;
      if ({count, Busy, Tc} !== {8'(ec[i]), 1'b1, et[i]}) begin
        bad++;
        $display("FAIL periodic_step%0d: got count=%0d busy=%b tc=%b want %0d/1/%b",
                 i, count, Busy, Tc, ec[i], et[i]);
      end
    end
    Stop = 1'b1;
    tick;
    Stop = 1'b0;
    total++;
    if ({count, Busy, Tc} !== {8'd2, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL periodic_stop: got count=%0d busy=%b tc=%b want 2/0/0", count, Busy, Tc);
    end
  endtask

  task automatic test_periodic_switch;
    Periodic = 1'b1; Enable = 1'b1; LoadValue = 8'd2; Load = 1'b1;
    tick;
    Load = 1'b0;
    tick;
    Periodic = 1'b0;
    tick;
    total++;
    if ({count, Busy, Tc} !== {8'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL periodic_switch_term: got count=%0d busy=%b tc=%b want 0/0/1", count, Busy, Tc);
    end
    tick;
    total++;
    if ({count, Busy, Tc} !== {8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL periodic_switch_after: got count=%0d busy=%b tc=%b want 0/0/0", count, Busy, Tc);
    end
  endtask

  task automatic test_pause;
    int ec[6] = '{5, 4, 4, 4, 3, 2};
    bit en[6] = '{1, 1, 0, 0, 1, 1};
    Periodic = 1'b0; Enable = 1'b1; LoadValue = 8'd6; Load = 1'b1;
    tick;
    Load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      Enable = en[i];
      tick;
      total++;
      if ({count, Busy, Tc} !== {8'(ec[i]), 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL pause_step%0d: got count=%0d busy=%b tc=%b want %0d/1/0",
                 i, count, Busy, Tc, ec[i]);
      end
    end
    // periodic reload value 1: terminal on every enabled edge; pausing must not stretch Tc
    Periodic = 1'b1; Enable = 1'b1; LoadValue = 8'd1; Load = 1'b1;
    tick;
    Load = 1'b0;
    tick;
    total++;
    if ({count, Busy, Tc} !== {8'd1, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL pause_tc_term: got count=%0d busy=%b tc=%b want 1/1/1", count, Busy, Tc);
    end
    Enable = 1'b0;
    tick;
    total++;
    if ({count, Busy, Tc} !== {8'd1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL pause_tc_hold: got count=%0d busy=%b tc=%b want 1/1/0", count, Busy, Tc);
    end
    Stop = 1'b1;
    tick;
    Stop = 1'b0; Periodic = 1'b0;
  endtask

  task automatic test_boundary;
    Enable = 1'b1; LoadValue = 8'd0; Load = 1'b1;
    tick;
    Load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({count, Busy, Tc} !== {8'd0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL load_zero_%0d: got count=%0d busy=%b tc=%b want 0/0/0", i, count, Busy, Tc);
      end
      tick;
    end
    LoadValue = 8'd255; Load = 1'b1;
    tick;
    Load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({count, Busy, Tc} !== {8'(255 - i), 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL load_max_%0d: got count=%0d busy=%b tc=%b want %0d/1/0",
                 i, count, Busy, Tc, 255 - i);
      end
      tick;
    end
    // load of 0 mid-run goes straight to IDLE with no terminal pulse
    LoadValue = 8'd0; Load = 1'b1;
    tick;
    Load = 1'b0;
    total++;
    if ({count, Busy, Tc} !== {8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL load_zero_midrun: got count=%0d busy=%b tc=%b want 0/0/0", count, Busy, Tc);
    end
  endtask

  task automatic test_stop_vs_load;
    Periodic = 1'b0; Enable = 1'b1; LoadValue = 8'd4; Load = 1'b1;
    tick;
    Load = 1'b0;
    tick;
    tick;
    Stop = 1'b1; Load = 1'b1; LoadValue = 8'd9;
    tick;
    Stop = 1'b0; Load = 1'b0;
    total++;
    if ({count, Busy, Tc} !== {8'd2, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL stop_over_load: got count=%0d busy=%b tc=%b want 2/0/0", count, Busy, Tc);
    end
    tick;
    total++;
    if ({count, Busy, Tc} !== {8'd2, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL stop_idle_hold: got count=%0d busy=%b tc=%b want 2/0/0", count, Busy, Tc);
    end
    Load = 1'b1;
    tick;
    Load = 1'b0;
    total++;
    if ({count, Busy, Tc} !== {8'd9, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL stop_then_load: got count=%0d busy=%b tc=%b want 9/1/0", count, Busy, Tc);
    end
    tick;
    total++;
    if ({count, Busy, Tc} !== {8'd8, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL stop_then_count: got count=%0d busy=%b tc=%b want 8/1/0", count, Busy, Tc);
    end
  endtask

  task automatic test_back_to_back;
    Periodic = 1'b0; Enable = 1'b1; LoadValue = 8'd5; Load = 1'b1;
    tick;
    Load = 1'b0;
    tick;
    LoadValue = 8'd2; Load = 1'b1;
    tick;
    Load = 1'b0;
    total++;
    if ({count, Busy, Tc} !== {8'd2, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL restart_load: got count=%0d busy=%b tc=%b want 2/1/0", count, Busy, Tc);
    end
    tick;
    tick;
    total++;
    if ({count, Busy, Tc} !== {8'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL restart_term: got count=%0d busy=%b tc=%b want 0/0/1", count, Busy, Tc);
    end
  endtask

  initial begin
    test_reset;
    test_oneshot;
    test_periodic;
    test_periodic_switch;
    test_pause;
    test_boundary;
    test_stop_vs_load;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
